// File: rtl/hp_display_pkg.sv
// Shared types and bar-pattern helpers for the HP/score LED displays.
package hp_display_pkg;

    localparam int unsigned MAX_LEDS = 64;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FILL,
        ERROR
    } state_e;

    // Alternating ...0101 pattern on the lowest n LEDs.
    function automatic logic [MAX_LEDS-1:0] err_pattern(input int unsigned n);
        logic [MAX_LEDS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_LEDS; i++) begin
            if ((i < n) && ((i % 2) == 0)) m[i] = 1'b1;
        end
        return m;
    endfunction

    // LED i lights when disp*n > i*max, i.e. ceil(disp*n/max) LEDs without a divider.
    function automatic logic [MAX_LEDS-1:0] bar_mask(input int unsigned disp,
                                                     input int unsigned n,
                                                     input int unsigned hp_max);
        logic [MAX_LEDS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_LEDS; i++) begin
            if ((i < n) && ((disp * n) > (i * hp_max))) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/hp_tick_gen.sv
// Modulo-DIV counter with synchronous clear; o_tick_c is high on the last count.
module hp_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick_c
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick_c = (r_cnt == LAST);

endmodule

// File: rtl/hp_bar_display.sv
// Per-player HP bar driver: scaled bar, animated drain/fill, low-HP blink,
// and an error pattern for out-of-range HP.
module hp_bar_display
    import hp_display_pkg::*;
#(
    parameter int unsigned NUM_LEDS   = 8,
    parameter int unsigned HP_W       = 4,
    parameter int unsigned HP_MAX     = 10,
    parameter int unsigned LOW_THRESH = 2,
    parameter int unsigned STEP_DIV   = 5_000_000,
    parameter int unsigned BLINK_DIV  = 12_500_000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [HP_W-1:0]     hp_in,
    input  logic                turn_in,
    output logic [NUM_LEDS-1:0] led_bar,
    output logic                turn_led,
    output logic                busy,
    output logic                err
);

    localparam logic [HP_W-1:0]     MAX_HP  = HP_W'(HP_MAX);
    localparam logic [HP_W-1:0]     LOW_HP  = HP_W'(LOW_THRESH);
    localparam logic [NUM_LEDS-1:0] ERR_BAR = NUM_LEDS'(err_pattern(NUM_LEDS));

    state_e              r_state;
    logic [HP_W-1:0]     r_disp_hp;
    logic [HP_W-1:0]     r_hp_q;
    logic                r_blink_phase;
    logic [NUM_LEDS-1:0] r_led_bar;
    logic                r_turn_led;
    logic                r_busy;
    logic                r_err;

    state_e              w_state_nxt;
    logic [HP_W-1:0]     w_disp_nxt;
    logic                w_phase_nxt;
    logic [NUM_LEDS-1:0] w_bar;
    logic [NUM_LEDS-1:0] w_led_nxt;
    logic                w_step_tick;
    logic                w_blink_tick;
    logic                w_step_clr;

    // Step pacing only runs while animating, so every step is a full STEP_DIV.
    assign w_step_clr = (r_state != DRAIN) && (r_state != FILL);

    hp_tick_gen #(.DIV(STEP_DIV)) u_step_tick (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_clr    (w_step_clr),
        .o_tick_c (w_step_tick)
    );

    hp_tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_clr    (1'b0),
        .o_tick_c (w_blink_tick)
    );

    // Next state and displayed HP; direction is re-evaluated only after a step.
    always_comb begin
        w_state_nxt = r_state;
        w_disp_nxt  = r_disp_hp;
        unique case (r_state)
            IDLE: begin
                if (r_hp_q > MAX_HP)         w_state_nxt = ERROR;
                else if (r_hp_q < r_disp_hp) w_state_nxt = DRAIN;
                else if (r_hp_q > r_disp_hp) w_state_nxt = FILL;
            end
            DRAIN, FILL: begin
                if (w_step_tick) begin
                    w_disp_nxt = (r_state == DRAIN) ? (r_disp_hp - HP_W'(1))
                                                    : (r_disp_hp + HP_W'(1));
                    if (r_hp_q > MAX_HP)          w_state_nxt = ERROR;
                    else if (r_hp_q < w_disp_nxt) w_state_nxt = DRAIN;
                    else if (r_hp_q > w_disp_nxt) w_state_nxt = FILL;
                    else                          w_state_nxt = IDLE;
                end else if (r_hp_q > MAX_HP) begin
                    w_state_nxt = ERROR;
                end
            end
            ERROR: begin
                if (r_hp_q <= MAX_HP) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_phase_nxt = r_blink_phase ^ w_blink_tick;

    // LED pattern for the upcoming cycle, registered below.
    always_comb begin
        w_bar     = NUM_LEDS'(bar_mask(32'(w_disp_nxt), NUM_LEDS, HP_MAX));
        w_led_nxt = w_bar;
        if (w_state_nxt == ERROR) begin
            w_led_nxt = ERR_BAR;
        end else if ((w_state_nxt == IDLE) && (w_disp_nxt != '0) && (w_disp_nxt <= LOW_HP)) begin
            w_led_nxt = w_bar & {NUM_LEDS{w_phase_nxt}};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= IDLE;
            r_disp_hp     <= MAX_HP;
            r_hp_q        <= MAX_HP;
            r_blink_phase <= 1'b1;
            r_led_bar     <= '1;
            r_turn_led    <= 1'b0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_disp_hp     <= w_disp_nxt;
            r_hp_q        <= hp_in;
            r_blink_phase <= w_phase_nxt;
            r_led_bar     <= w_led_nxt;
            r_turn_led    <= turn_in;
            r_busy        <= (w_state_nxt == DRAIN) || (w_state_nxt == FILL);
            r_err         <= (w_state_nxt == ERROR);
        end
    end

    assign led_bar  = r_led_bar;
    assign turn_led = r_turn_led;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule

// File: tb/tb_hp_bar_display.sv
// Bench for hp_bar_display: directed scenarios plus randomized HP traffic,
// checked every cycle against a behavioural model of the display rules.
module tb_hp_bar_display;

    localparam int NL     = 8;
    localparam int HPW    = 4;
    localparam int HPMAX  = 10;
    localparam int LOW    = 2;
    localparam int SDIV   = 4;
    localparam int BDIV   = 8;

    localparam int M_IDLE  = 0;
    localparam int M_DRAIN = 1;
    localparam int M_FILL  = 2;
    localparam int M_ERR   = 3;

    logic           CLK;
    logic           RST;
    logic [HPW-1:0] hp_in;
    logic           turn_in;
    logic [NL-1:0]  led_bar;
    logic           turn_led;
    logic           busy;
    logic           err;

    int total = 0;
    int bad   = 0;
    bit done  = 0;
    logic [NL-1:0] min_led;

    typedef struct {
        int hpq;
        int disp;
        int mode;
        int step;
        int bcnt;
        bit phase;
        bit turn;
    } model_t;

    model_t m;

    hp_bar_display #(
        .NUM_LEDS   (NL),
        .HP_W       (HPW),
        .HP_MAX     (HPMAX),
        .LOW_THRESH (LOW),
        .STEP_DIV   (SDIV),
        .BLINK_DIV  (BDIV)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .hp_in    (hp_in),
        .turn_in  (turn_in),
        .led_bar  (led_bar),
        .turn_led (turn_led),
        .busy     (busy),
        .err      (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One clock of the display rules, from the registered target hpq.
    function automatic model_t model_step(input model_t s, input int hin, input bit tin);
        model_t n;
        n      = s;
        n.hpq  = hin;
        n.turn = tin;
        if (s.bcnt == BDIV - 1) begin
            n.bcnt  = 0;
            n.phase = !s.phase;
        end else begin
            n.bcnt = s.bcnt + 1;
        end
        case (s.mode)
            M_IDLE: begin
                if (s.hpq > HPMAX) n.mode = M_ERR;
                else if (s.hpq < s.disp) begin n.mode = M_DRAIN; n.step = 0; end
                else if (s.hpq > s.disp) begin n.mode = M_FILL;  n.step = 0; end
            end
            M_DRAIN, M_FILL: begin
                if (s.step == SDIV - 1) begin
                    n.step = 0;
                    n.disp = (s.mode == M_DRAIN) ? s.disp - 1 : s.disp + 1;
                    if (s.hpq > HPMAX)       n.mode = M_ERR;
                    else if (s.hpq < n.disp) n.mode = M_DRAIN;
                    else if (s.hpq > n.disp) n.mode = M_FILL;
                    else                     n.mode = M_IDLE;
                end else begin
                    n.step = s.step + 1;
                    if (s.hpq > HPMAX) n.mode = M_ERR;
                end
            end
            default: begin
                if (s.hpq <= HPMAX) n.mode = M_IDLE;
            end
        endcase
        return n;
    endfunction

    function automatic logic [NL-1:0] exp_led(input model_t s);
        int lit;
        logic [NL-1:0] bar;
        if (s.mode == M_ERR) return 8'h55;
        lit = (s.disp * NL + HPMAX - 1) / HPMAX;
        bar = NL'((1 << lit) - 1);
        if (s.mode == M_IDLE && s.disp >= 1 && s.disp <= LOW && !s.phase) bar = '0;
        return bar;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) m <= '{hpq: HPMAX, disp: HPMAX, mode: M_IDLE, step: 0, bcnt: 0, phase: 1'b1, turn: 1'b0};
        else     m <= model_step(m, int'(hp_in), turn_in);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled between edges.
    always begin
        @(posedge CLK);
        #3;
        if (!done) begin
            check("model_led",  32'(led_bar),  32'(exp_led(m)));
            check("model_busy", 32'(busy),     32'((m.mode == M_DRAIN) || (m.mode == M_FILL)));
            check("model_err",  32'(err),      32'(m.mode == M_ERR));
            check("model_turn", 32'(turn_led), 32'(m.turn));
        end
    end

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        repeat (3) begin
            @(negedge CLK);
            if (led_bar < min_led) min_led = led_bar;
        end
        while ((busy || err) && n < max_cycles) begin
            @(negedge CLK);
            if (led_bar < min_led) min_led = led_bar;
            n++;
        end
        if (busy || err) begin
            total++;
            bad++;
            $display("FAIL wait_idle: still busy=%0b err=%0b after %0d cycles", busy, err, max_cycles);
        end
    endtask

    initial begin
        bit saw_on, saw_off, saw_other;
        int nonzero;
        int r, hold;

        RST = 1'b1; hp_in = 4'd10; turn_in = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_led",  32'(led_bar),  32'h0FF);
        check("rst_busy", 32'(busy),     32'h0);
        check("rst_err",  32'(err),      32'h0);
        check("rst_turn", 32'(turn_led), 32'h0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("idle_full", 32'(led_bar), 32'h0FF);

        // Drain 10 -> 7, one step every SDIV clocks.
        hp_in = 4'd7;
        @(negedge CLK);  check("busy_t1", 32'(busy), 32'h0);
        @(negedge CLK);  check("busy_t2", 32'(busy), 32'h1);
        repeat (7) @(negedge CLK);
        check("hp9_led", 32'(led_bar), 32'h0FF);
        @(negedge CLK);
        check("hp8_led", 32'(led_bar), 32'h07F);
        repeat (3) @(negedge CLK);
        check("hp8_busy", 32'(busy), 32'h1);
        check("hp8_hold", 32'(led_bar), 32'h07F);
        @(negedge CLK);
        check("hp7_led",  32'(led_bar), 32'h03F);
        check("hp7_busy", 32'(busy), 32'h0);

        hp_in = 4'd3; wait_idle(100);
        check("hp3_led", 32'(led_bar), 32'h007);

        // Low HP blinks.
        hp_in = 4'd2; wait_idle(100);
        saw_on = 0; saw_off = 0; saw_other = 0;
        repeat (24) begin
            @(negedge CLK);
            if (led_bar == 8'h03) saw_on = 1;
            else if (led_bar == 8'h00) saw_off = 1;
            else saw_other = 1;
        end
        check("blink_seen", 32'({saw_on, saw_off, saw_other}), 32'b110);

        hp_in = 4'd0; wait_idle(100);
        nonzero = 0;
        repeat (20) begin
            @(negedge CLK);
            if (led_bar != 8'h00) nonzero++;
        end
        check("zero_steady", 32'(nonzero), 32'd0);

        hp_in = 4'd10; wait_idle(200);
        check("refill_led", 32'(led_bar), 32'h0FF);

        // Out-of-range HP mid-drain, then recovery.
        hp_in = 4'd5;
        repeat (6) @(negedge CLK);
        check("pre_err_busy", 32'(busy), 32'h1);
        hp_in = 4'd13;
        repeat (2) @(negedge CLK);
        check("err_led",  32'(led_bar), 32'h055);
        check("err_flag", 32'(err),     32'h1);
        check("err_busy", 32'(busy),    32'h0);
        hp_in = 4'd4;
        repeat (2) @(negedge CLK);
        check("err_clear", 32'(err), 32'h0);
        wait_idle(100);
        check("hp4_led", 32'(led_bar), 32'h00F);

        hp_in = 4'd6; wait_idle(100);
        check("hp6_led", 32'(led_bar), 32'h01F);

        // Reverse direction while draining from 6.
        hp_in = 4'd3;
        repeat (3) @(negedge CLK);
        hp_in = 4'd9;
        min_led = 8'hFF;
        wait_idle(100);
        check("reverse_min", 32'(min_led), 32'h00F);
        check("reverse_end", 32'(led_bar), 32'h0FF);

        // Reset in the middle of a fill.
        hp_in = 4'd2; wait_idle(200);
        hp_in = 4'd8;
        repeat (8) @(negedge CLK);
        check("fill_busy", 32'(busy), 32'h1);
        RST = 1'b1; hp_in = 4'd4;
        #1;
        check("rst_mid_led",  32'(led_bar), 32'h0FF);
        check("rst_mid_busy", 32'(busy),    32'h0);
        @(negedge CLK);
        RST = 1'b0;
        wait_idle(100);
        check("post_rst_led", 32'(led_bar), 32'h00F);

        check("turn_lo", 32'(turn_led), 32'h0);
        turn_in = 1'b1;
        @(negedge CLK); check("turn_hi", 32'(turn_led), 32'h1);
        turn_in = 1'b0;
        @(negedge CLK); check("turn_back", 32'(turn_led), 32'h0);

        // Randomized traffic, including per-cycle retargeting and reset pulses.
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 19);
            hold = $urandom_range(1, 10);
            if ($urandom_range(0, 5) == 0) begin
                repeat (hold) begin
                    @(negedge CLK);
                    hp_in = HPW'($urandom_range(0, 10));
                    turn_in = 1'($urandom_range(0, 1));
                end
            end else begin
                @(negedge CLK);
                hp_in = (r < 16) ? HPW'(r) : HPW'($urandom_range(0, 10));
                repeat (hold) begin
                    @(negedge CLK);
                    turn_in = 1'($urandom_range(0, 1));
                end
            end
            if ($urandom_range(0, 40) == 0) begin
                @(negedge CLK);
                RST = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge CLK);
                RST = 1'b0;
            end
        end

        repeat (2) @(negedge CLK);
        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
